// File: rtl/uart_tx_drain_if.sv
// Queue-side port bundle of the UART transmit drain: head data, flags and the pop strobe.
// q_remove pops the head entry on the clock edge where it is high; it is raised only while q_empty = 0 and q_add = 0.
interface uart_tx_drain_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] q_data;
   logic                  q_empty;
   logic                  q_add;
   logic                  q_remove;

   modport master (
      input  q_data,
      input  q_empty,
      input  q_add,
      output q_remove
   );

   modport slave (
      output q_data,
      output q_empty,
      output q_add,
      input  q_remove
   );
endinterface

// File: rtl/uart_tx_drain.sv
// Drains the byte queue and sends each entry as an 8N1 UART frame (start, 8 data LSB first, stop).
// tx/tx_busy are registered from the next state so the line never glitches.
module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   uart_tx_drain_if.master     qif,
   output logic                tx,
   output logic                tx_busy,
   output logic                tx_done,
   output logic [1:0]          dbg_state
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2:0]            bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pop;
   logic                  bit_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      bit_end = (cnt_q == CNT_LAST);

      case (state_q)
         IDLE: begin
            // The queue favours add over remove, so never pop while a push is in flight.
            pop = rst_n & enable & ~qif.q_empty & ~qif.q_add;
            if (pop) begin
               shift_d = qif.q_data;
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign qif.q_remove = pop;
   assign tx           = tx_q;
   assign tx_busy      = busy_q;
   assign tx_done      = done_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a queue model feeds the DUT, expected frames come from the bytes pushed.
// Two extra instances exercise CLKS_PER_BIT = 2 and 434 with a single 0x81 frame each.
module tb_uart_tx_drain;

   localparam int CPB   = 4;
   localparam int LIMIT = 3000;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   logic [7:0] add_byte;
   logic [1:0] aux_push;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rem_cnt  = 0;
   int done_cnt = 0;
   int aux_n0   = 0;
   int aux_n1   = 0;
   int aux_rem0 = 0;
   int aux_rem1 = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];

   uart_tx_drain_if #(.DATA_WIDTH(8)) mif ();
   uart_tx_drain_if #(.DATA_WIDTH(8)) aif2 ();
   uart_tx_drain_if #(.DATA_WIDTH(8)) aif434 ();

   logic [2:0] tx_v, busy_v, done_v;
   logic [1:0] st_main, st_a2, st_a434;

   always #5 clk = ~clk;

   uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .qif(mif),
      .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .dbg_state(st_main)
   );

   uart_tx_drain #(.CLKS_PER_BIT(2), .DATA_WIDTH(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .enable(1'b1), .qif(aif2),
      .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .dbg_state(st_a2)
   );

   uart_tx_drain #(.CLKS_PER_BIT(434), .DATA_WIDTH(8)) u_dut434 (
      .clk(clk), .rst_n(rst_n), .enable(1'b1), .qif(aif434),
      .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .dbg_state(st_a434)
   );

   assign aif2.q_add   = 1'b0;
   assign aif434.q_add = 1'b0;

   // Queue model: add wins over remove, head data and empty flag follow the stored contents.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mif.q_add) mq.push_back(add_byte);
      if (mif.q_remove && mq.size() > 0) void'(mq.pop_front());
      if (mif.q_remove) rem_cnt <= rem_cnt + 1;
      if (done_v[0]) done_cnt <= done_cnt + 1;
      mif.q_data  <= (mq.size() > 0) ? mq[0] : 8'h00;
      mif.q_empty <= (mq.size() == 0);

      if (aux_push[0]) aux_n0 = aux_n0 + 1;
      if (aif2.q_remove) begin
         aux_n0   = aux_n0 - 1;
         aux_rem0 <= aux_rem0 + 1;
      end
      aif2.q_data  <= 8'h81;
      aif2.q_empty <= (aux_n0 <= 0);

      if (aux_push[1]) aux_n1 = aux_n1 + 1;
      if (aif434.q_remove) begin
         aux_n1   = aux_n1 - 1;
         aux_rem1 <= aux_rem1 + 1;
      end
      aif434.q_data  <= 8'h81;
      aif434.q_empty <= (aux_n1 <= 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the byte enters the queue on the next posedge.
   task automatic push(input logic [7:0] b);
      mif.q_add = 1'b1;
      add_byte  = b;
      exp_q.push_back(b);
      @(negedge clk);
      mif.q_add = 1'b0;
   endtask

   // Waits for the start bit, then checks every cycle of all ten bits plus the tx_done cycle.
   task automatic check_frame(input int idx, input int cpb, input logic [7:0] b,
                              input int drop_at, input string tag, output int start_cyc);
      int n;
      logic expb, obs_tx, obs_busy;
      n = 0;
      while (tx_v[idx] !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start_seen"}, 32'(n < LIMIT), 32'd1);
      start_cyc = cyc;
      if (n >= LIMIT) return;
      for (int k = 0; k < 10; k++) begin
         expb     = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         obs_tx   = expb;
         obs_busy = 1'b1;
         if (k == drop_at) enable = 1'b0;
         for (int c = 0; c < cpb; c++) begin
            if (tx_v[idx] !== expb) obs_tx = tx_v[idx];
            if (busy_v[idx] !== 1'b1) obs_busy = busy_v[idx];
            @(negedge clk);
         end
         chk($sformatf("%s_tx_bit%0d", tag, k), 32'(obs_tx), 32'(expb));
         chk($sformatf("%s_busy_bit%0d", tag, k), 32'(obs_busy), 32'd1);
      end
      chk({tag, "_done"}, 32'(done_v[idx]), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy_v[idx]), 32'd0);
      chk({tag, "_tx_end"}, 32'(tx_v[idx]), 32'd1);
   endtask

   initial begin
      int s0, s1, r0, d0, bad;
      logic [7:0] b;
      rst_n     = 1'b0;
      enable    = 1'b0;
      mif.q_add = 1'b0;
      add_byte  = 8'h00;
      aux_push  = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_v[0]), 32'd1);
      chk("rst_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_done", 32'(done_v[0]), 32'd0);
      chk("rst_remove", 32'(mif.q_remove), 32'd0);
      chk("rst_state", 32'(st_main), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte 0xA5, held back by enable = 0 first.
      push(8'hA5);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (mif.q_remove !== 1'b0 || tx_v[0] !== 1'b1) bad++;
      end
      chk("disabled_hold", bad, 0);
      r0 = rem_cnt; d0 = done_cnt;
      enable = 1'b1;
      check_frame(0, CPB, exp_q.pop_front(), -1, "a5", s0);
      @(negedge clk);
      chk("a5_pops", rem_cnt - r0, 1);
      chk("a5_dones", done_cnt - d0, 1);
      chk("a5_empty", 32'(mif.q_empty), 32'd1);

      // Back-to-back frames.
      enable = 1'b0;
      push(8'h00); push(8'hFF); push(8'h3C);
      r0 = rem_cnt;
      enable = 1'b1;
      check_frame(0, CPB, exp_q.pop_front(), -1, "b2b0", s0);
      check_frame(0, CPB, exp_q.pop_front(), -1, "b2b1", s1);
      chk("b2b_period1", s1 - s0, 10 * CPB + 1);
      s0 = s1;
      check_frame(0, CPB, exp_q.pop_front(), -1, "b2b2", s1);
      chk("b2b_period2", s1 - s0, 10 * CPB + 1);
      repeat (3) @(negedge clk);
      chk("b2b_pops", rem_cnt - r0, 3);
      chk("b2b_empty", 32'(mif.q_empty), 32'd1);
      chk("b2b_tx_idle", 32'(tx_v[0]), 32'd1);

      // Add conflict: 0x55 waiting, producer pushes random bytes for 5 cycles.
      enable = 1'b0;
      push(8'h55);
      enable = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         mif.q_add = 1'b1;
         add_byte  = 8'($urandom_range(0, 255));
         exp_q.push_back(add_byte);
         #1;
         if (mif.q_remove !== 1'b0) bad++;
         @(negedge clk);
      end
      mif.q_add = 1'b0;
      chk("conflict_held", bad, 0);
      #1;
      chk("conflict_release", 32'(mif.q_remove), 32'd1);
      check_frame(0, CPB, exp_q.pop_front(), -1, "conflict55", s0);
      for (int i = 0; i < 5; i++)
         check_frame(0, CPB, exp_q.pop_front(), -1, $sformatf("rnd%0d", i), s0);
      @(negedge clk);
      chk("rnd_empty", 32'(mif.q_empty), 32'd1);

      // Enable control with two queued bytes.
      enable = 1'b0;
      push(8'($urandom_range(0, 255)));
      push(8'($urandom_range(0, 255)));
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (mif.q_remove !== 1'b0 || tx_v[0] !== 1'b1) bad++;
      end
      chk("en_low_hold", bad, 0);
      enable = 1'b1;
      check_frame(0, CPB, exp_q.pop_front(), 3, "en_drop", s0);
      r0 = rem_cnt;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (mif.q_remove !== 1'b0 || tx_v[0] !== 1'b1) bad++;
      end
      chk("en_drop_hold", bad, 0);
      chk("en_drop_nopop", rem_cnt - r0, 0);
      chk("en_drop_queued", 32'(mif.q_empty), 32'd0);

      // Reset during data bit 3; the popped byte is lost.
      enable = 1'b1;
      bad = 0;
      while (tx_v[0] !== 1'b0 && bad < LIMIT) begin
         @(negedge clk);
         bad++;
      end
      chk("rstmid_start_seen", 32'(bad < LIMIT), 32'd1);
      repeat (4 * CPB + 1) @(negedge clk);
      chk("rstmid_in_data", 32'(st_main), 32'd2);
      void'(exp_q.pop_front());
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_tx", 32'(tx_v[0]), 32'd1);
      chk("rstmid_busy", 32'(busy_v[0]), 32'd0);
      @(negedge clk);
      b = 8'($urandom_range(0, 255));
      push(b);
      #1;
      chk("rstmid_no_pop", 32'(mif.q_remove), 32'd0);
      r0 = rem_cnt; d0 = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstmid_done_low", 32'(done_v[0]), 32'd0);
      chk("rstmid_idle", 32'(st_main), 32'd0);
      check_frame(0, CPB, exp_q.pop_front(), -1, "after_rst", s0);
      @(negedge clk);
      chk("after_rst_pops", rem_cnt - r0, 1);
      chk("after_rst_dones", done_cnt - d0, 1);

      // Bit-period extremes with a 0x81 frame.
      aux_push[0] = 1'b1;
      @(negedge clk);
      aux_push[0] = 1'b0;
      check_frame(1, 2, 8'h81, -1, "cpb2", s0);
      aux_push[1] = 1'b1;
      @(negedge clk);
      aux_push[1] = 1'b0;
      check_frame(2, 434, 8'h81, -1, "cpb434", s0);
      repeat (3) @(negedge clk);
      chk("cpb2_pops", aux_rem0, 1);
      chk("cpb434_pops", aux_rem1, 1);
      chk("cpb2_idle", 32'(st_a2), 32'd0);
      chk("cpb434_idle", 32'(st_a434), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
